// File: rtl/uart_rx_sink_if.sv
// rtl/uart_rx_sink_if.sv - byte output handshake between uart_rx_sink and its consumer
interface uart_rx_sink_if;
  logic [7:0] dout_data;
  logic       dout_valid;
  logic       dout_ready;

  modport master (output dout_data, output dout_valid, input dout_ready);
  modport slave  (input dout_data, input dout_valid, output dout_ready);
endinterface

// File: rtl/uart_rx_sink.sv
// rtl/uart_rx_sink.sv - 8N1 UART receiver feeding a first-word fall-through byte FIFO
module uart_rx_sink #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  uart_rx_sink_if.master                  dout,
  output logic                            frame_err,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t         state, state_n;
  logic           rx_meta, rx_s;
  logic [CW-1:0]  clk_cnt, clk_cnt_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     shift, shift_n;
  logic           push;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [NW-1:0]  count;
  logic           full, pop, wr_en;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
    end
  end

  // Frame decoding: mid-bit sampling, LSB-first shift, stop-bit verdict.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        bit_cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err = 1'b1;
            state_n   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        clk_cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        clk_cnt_n = '0;
        state_n   = IDLE;
      end
    endcase
  end

  assign full     = (count == CNT_FULL);
  assign pop      = dout.dout_valid & dout.dout_ready;
  assign wr_en    = push & (~full | pop);
  assign overflow = push & full & ~pop;

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Byte storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift;
  end

  assign dout.dout_valid = (count != '0);
  assign dout.dout_data  = dout.dout_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count      = count;

endmodule

// File: tb/tb_uart_rx_sink.sv
// tb/tb_uart_rx_sink.sv - randomized self-checking bench for uart_rx_sink
module tb_uart_rx_sink;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int CNTW  = $clog2(DEPTH + 1);
  // Clock edge, counted from the edge before the start bit is driven, on which
  // the stop-bit centre is sampled: two sync flops, one edge to leave IDLE,
  // half a bit to the start centre, then eight data bits and the stop bit.
  localparam int PUSH_EDGE = 2 + 1 + CPB / 2 + 9 * CPB;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx = 1'b1;
  logic            frame_err, overflow;
  logic [CNTW-1:0] fifo_count;

  uart_rx_sink_if ifc();

  uart_rx_sink #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .dout       (ifc),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         fe_cnt   = 0;
  int         ovf_cnt  = 0;
  int         exp_fe   = 0;
  int         exp_ovf  = 0;
  bit         rand_ready_en = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pulse counting and popped-byte scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (overflow) ovf_cnt++;
      if (frame_err || overflow) check("fe_ovf_exclusive", {31'b0, frame_err & overflow}, 32'd0);
      if (ifc.dout_valid && ifc.dout_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else check("pop_data", {24'b0, ifc.dout_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // Random consumer back-pressure during the randomized phase.
  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1 ifc.dout_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_raw(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
  endtask

  // Reference: a good frame is queued unless the FIFO is full; a bad stop bit is a framing error.
  task automatic model_frame(input logic [7:0] b, input bit stop);
    if (!stop) exp_fe++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf++;
  endtask

  task automatic deliver(input logic [7:0] b, input bit stop);
    send_raw(b, stop);
    model_frame(b, stop);
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    ifc.dout_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH + 10 && !done; i++) begin
      idle(1);
      if (!ifc.dout_valid) done = 1'b1;
    end
    ifc.dout_ready = 1'b0;
    check({tag, "_drain_done"}, {31'b0, done}, 32'd1);
    check({tag, "_model_empty"}, exp_q.size(), 32'd0);
    check({tag, "_count_zero"}, {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    bit         stop;
    ifc.dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, ifc.dout_valid}, 32'd0);
    check("rst_data", {24'b0, ifc.dout_data}, 32'd0);
    check("rst_count", {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);
    check("rst_fe", {31'b0, frame_err}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;
    idle(2 * CPB);

    // 1: single byte, fall-through, one-cycle pop
    deliver(8'h55, 1'b1);
    idle(CPB);
    check("t1_valid", {31'b0, ifc.dout_valid}, 32'd1);
    check("t1_data", {24'b0, ifc.dout_data}, 32'h55);
    check("t1_count", {{(32-CNTW){1'b0}}, fifo_count}, 32'd1);
    ifc.dout_ready = 1'b1;
    idle(1);
    ifc.dout_ready = 1'b0;
    idle(1);
    check("t1_valid_after_pop", {31'b0, ifc.dout_valid}, 32'd0);
    check("t1_count_after_pop", {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);

    // 2: start-bit glitch rejected, following frame intact
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(3 * CPB);
    check("t2_glitch_count", {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);
    check("t2_glitch_fe", fe_cnt, 32'd0);
    deliver(8'hC3, 1'b1);
    idle(CPB);
    check("t2_count", {{(32-CNTW){1'b0}}, fifo_count}, 32'd1);
    drain("t2");

    // 3: framing error then a long break, recovery
    deliver(8'hA3, 1'b0);
    idle(20 * CPB);
    check("t3_fe_single", fe_cnt, exp_fe);
    check("t3_count", {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);
    rx = 1'b1;
    idle(2 * CPB);
    deliver(8'h3C, 1'b1);
    idle(CPB);
    check("t3_count_after", {{(32-CNTW){1'b0}}, fifo_count}, 32'd1);
    drain("t3");

    // 4: fill past capacity, back-to-back frames
    for (int i = 0; i <= 8; i++) deliver(8'(i), 1'b1);
    idle(CPB);
    check("t4_count_full", {{(32-CNTW){1'b0}}, fifo_count}, 32'd8);
    check("t4_ovf", ovf_cnt, exp_ovf);
    drain("t4");

    // 5: push and pop on the same edge while full
    for (int i = 0; i < 8; i++) deliver(8'h10 + 8'(i), 1'b1);
    idle(CPB);
    check("t5_count_full", {{(32-CNTW){1'b0}}, fifo_count}, 32'd8);
    fork
      send_raw(8'h18, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) @(posedge clk);
        #1 ifc.dout_ready = 1'b1;
        @(posedge clk);
        #1 ifc.dout_ready = 1'b0;
      end
    join
    model_frame(8'h18, 1'b1);
    idle(CPB);
    check("t5_count_still_full", {{(32-CNTW){1'b0}}, fifo_count}, 32'd8);
    check("t5_no_ovf", ovf_cnt, exp_ovf);
    drain("t5");

    // 6: asynchronous reset mid-frame
    deliver(8'h42, 1'b1);
    idle(CPB);
    check("t6_count_pre", {{(32-CNTW){1'b0}}, fifo_count}, 32'd1);
    b = 8'h5A;
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = b[3];
    idle(CPB / 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, ifc.dout_valid}, 32'd0);
    check("t6_rst_data", {24'b0, ifc.dout_data}, 32'd0);
    check("t6_rst_count", {{(32-CNTW){1'b0}}, fifo_count}, 32'd0);
    check("t6_rst_fe", {31'b0, frame_err}, 32'd0);
    check("t6_rst_ovf", {31'b0, overflow}, 32'd0);
    exp_q.delete();
    rx = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2 * CPB);
    deliver(8'h81, 1'b1);
    idle(CPB);
    check("t6_count_after", {{(32-CNTW){1'b0}}, fifo_count}, 32'd1);
    drain("t6");

    // Randomized frames, stop-bit errors, glitches and back-pressure
    rand_ready_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      deliver(b, stop);
      if (!stop) begin
        rx = 1'b1;
        idle(2 * CPB);
      end else begin
        idle($urandom_range(0, 6));
      end
      if ($urandom_range(0, 5) == 0) begin
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(3 * CPB);
      end
    end
    idle(2 * CPB);
    rand_ready_en = 1'b0;
    idle(2);
    drain("rand");
    check("rand_fe", fe_cnt, exp_fe);
    check("rand_ovf", ovf_cnt, exp_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
